rfile_wb_ctrl: RTL and testbench

Write-back arbiter and hazard scoreboard for the 32×32 integer register file (`rfile`). It shares the register file's single write port between two requesters, the ALU and the load/store unit, using a valid/ready handshake. It also keeps one pending bit per architectural register and stalls the issue stage on RAW/WAW hazards. It sits between the execute/memory units and `rfile`, and drives `rd`/`rd_data`/`rd_valid` and the read-port selects.

---
 rtl/rfile_pkg.sv | 15 +
 rtl/rfile_scoreboard.sv | 54 +++++
 rtl/rfile_wb_ctrl.sv | 129 ++++++++++++
 tb/tb_rfile_wb_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfile_pkg.sv
// rtl/rfile_pkg.sv - shared register-file constants and requester encoding
// Purpose: widths and the write-back requester enum, shared by rfile,
//          the issue stage and the write-back controller.
// Ports:   none (package)
// Config:  none here; RFILE_WB_RR_EN is consumed by rfile_wb_ctrl
package rfile_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;
endpackage

// File: rtl/rfile_scoreboard.sv
// rtl/rfile_scoreboard.sv - per-register pending bits, hazard stall, write-back error
// Purpose: tracks which architectural registers have a write in flight and
//          stalls issue on RAW/WAW hazards against them.
// Ports:   clk, reset            clock, synchronous active-high reset
//          iss_*                 issue-stage operand/destination description
//          iss_stall             combinational hazard stall
//          gnt_valid, gnt_rd     write-back granted this cycle and its rd
//          clr_valid, clr_rd     rfile write this cycle (clears pending)
//          wb_err                sticky: granted write to a non-pending register
module rfile_scoreboard
  import rfile_pkg::*;
#(
  parameter int NREG_P = NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_rs1_used,
  input  logic                 iss_rs2_used,
  input  logic                 iss_writes,
  output logic                 iss_stall,
  input  logic                 gnt_valid,
  input  logic [REG_IDX_W-1:0] gnt_rd,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_rd,
  output logic                 wb_err
);
  logic [NREG_P-1:0] r_pend;
  logic              r_err;
  logic              w_fire;

  assign iss_stall = iss_valid & ((iss_rs1_used & r_pend[iss_rs1]) |
                                  (iss_rs2_used & r_pend[iss_rs2]) |
                                  (iss_writes   & r_pend[iss_rd]));
  assign w_fire = iss_valid & ~iss_stall & iss_writes & (iss_rd != '0);
  assign wb_err = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      // Clear first so a same-edge set of the same bit wins.
      if (clr_valid) r_pend[clr_rd] <= 1'b0;
      if (w_fire)    r_pend[iss_rd] <= 1'b1;
      r_pend[0] <= 1'b0;
      // Checked at grant time, while the bit of a legal write is still set.
      if (gnt_valid && (gnt_rd != '0) && !r_pend[gnt_rd]) r_err <= 1'b1;
    end
  end
endmodule

// File: rtl/rfile_wb_ctrl.sv
// rtl/rfile_wb_ctrl.sv - write-back arbiter and hazard scoreboard for rfile
// Purpose: shares the rfile write port between ALU and LSU, registers the
//          granted write, and stalls issue on pending-register hazards.
// Ports:   clk, reset                         clock, synchronous active-high reset
//          alu_wb_* / lsu_wb_*                valid/rd/data in, ready out
//          iss_*                              issue description in, iss_stall out
//          src_rs1/2, rs1_valid/rs2_valid     rfile read selects and enables
//          rd, rd_data, rd_valid              registered rfile write port
//          wb_err                             sticky write-back error
// Config:  RFILE_WB_RR_EN defined -> round-robin; undefined -> LSU fixed priority
module rfile_wb_ctrl
  import rfile_pkg::*;
#(
  parameter int XLEN = rfile_pkg::XLEN,
  parameter int NREG = rfile_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_wb_valid,
  input  logic [REG_IDX_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]      alu_wb_data,
  output logic                 alu_wb_ready,
  input  logic                 lsu_wb_valid,
  input  logic [REG_IDX_W-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]      lsu_wb_data,
  output logic                 lsu_wb_ready,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic                 iss_rs1_used,
  input  logic                 iss_rs2_used,
  input  logic                 iss_writes,
  output logic                 iss_stall,
  output logic [REG_IDX_W-1:0] src_rs1,
  output logic [REG_IDX_W-1:0] src_rs2,
  output logic                 rs1_valid,
  output logic                 rs2_valid,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_data,
  output logic                 rd_valid,
  output logic                 wb_err
);
  logic                 w_alu_gnt;
  logic                 w_lsu_gnt;
  logic                 w_gnt;
  logic [REG_IDX_W-1:0] w_gnt_rd;
  logic [XLEN-1:0]      w_gnt_data;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_rd_data;
  logic                 r_rd_valid;

`ifdef RFILE_WB_RR_EN
  // Last-granted requester; reset to LSU so the first conflict goes to ALU.
  req_e r_last;

  always_comb begin
    w_alu_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    if (!reset) begin
      if (alu_wb_valid && lsu_wb_valid) begin
        if (r_last == REQ_ALU) w_lsu_gnt = 1'b1;
        else                   w_alu_gnt = 1'b1;
      end else begin
        w_alu_gnt = alu_wb_valid;
        w_lsu_gnt = lsu_wb_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          r_last <= REQ_LSU;
    else if (w_alu_gnt) r_last <= REQ_ALU;
    else if (w_lsu_gnt) r_last <= REQ_LSU;
  end
`else
  always_comb begin
    w_lsu_gnt = ~reset & lsu_wb_valid;
    w_alu_gnt = ~reset & alu_wb_valid & ~lsu_wb_valid;
  end
`endif

  assign alu_wb_ready = w_alu_gnt;
  assign lsu_wb_ready = w_lsu_gnt;
  assign w_gnt        = w_alu_gnt | w_lsu_gnt;
  assign w_gnt_rd     = w_lsu_gnt ? lsu_wb_rd   : alu_wb_rd;
  assign w_gnt_data   = w_lsu_gnt ? lsu_wb_data : alu_wb_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd       <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      // A grant to x0 is consumed without raising the rfile write enable.
      r_rd_valid <= w_gnt & (w_gnt_rd != '0);
      if (w_gnt) begin
        r_rd      <= w_gnt_rd;
        r_rd_data <= w_gnt_data;
      end
    end
  end

  assign rd       = r_rd;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign src_rs1  = iss_rs1;
  assign src_rs2  = iss_rs2;
  assign rs1_valid = iss_valid & iss_rs1_used & ~iss_stall;
  assign rs2_valid = iss_valid & iss_rs2_used & ~iss_stall;

  rfile_scoreboard #(.NREG_P(NREG)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_used (iss_rs2_used),
    .iss_writes   (iss_writes),
    .iss_stall    (iss_stall),
    .gnt_valid    (w_gnt),
    .gnt_rd       (w_gnt_rd),
    .clr_valid    (r_rd_valid),
    .clr_rd       (r_rd),
    .wb_err       (wb_err)
  );
endmodule

// File: tb/tb_rfile_wb_ctrl.sv
// tb/tb_rfile_wb_ctrl.sv - self-checking bench for rfile_wb_ctrl
module tb_rfile_wb_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wb_valid, lsu_wb_valid;
  logic [4:0]  alu_wb_rd, lsu_wb_rd;
  logic [31:0] alu_wb_data, lsu_wb_data;
  logic        alu_wb_ready, lsu_wb_ready;
  logic        iss_valid, iss_rs1_used, iss_rs2_used, iss_writes;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall, rs1_valid, rs2_valid, rd_valid, wb_err;
  logic [4:0]  src_rs1, src_rs2, rd;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  rfile_wb_ctrl dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rs1_used(iss_rs1_used), .iss_rs2_used(iss_rs2_used), .iss_writes(iss_writes),
    .iss_stall(iss_stall), .src_rs1(src_rs1), .src_rs2(src_rs2),
    .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rd(rd), .rd_data(rd_data), .rd_valid(rd_valid), .wb_err(wb_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  wb_t  alu_q[$];
  wb_t  lsu_q[$];
  int   gnt_log[$];   // 0 = ALU, 1 = LSU

  // Reference state: architectural meaning only.
  bit [31:0]   m_pend;
  bit          m_err;
  bit          m_rdv;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_last_lsu;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_err = 0; m_rdv = 0; m_rd = '0; m_data = '0; m_last_lsu = 1;
  endtask

  task automatic drive_reqs();
    alu_wb_valid = (alu_q.size() > 0);
    alu_wb_rd    = alu_wb_valid ? alu_q[0].rd : 5'd0;
    alu_wb_data  = alu_wb_valid ? alu_q[0].d  : 32'd0;
    lsu_wb_valid = (lsu_q.size() > 0);
    lsu_wb_rd    = lsu_wb_valid ? lsu_q[0].rd : 5'd0;
    lsu_wb_data  = lsu_wb_valid ? lsu_q[0].d  : 32'd0;
  endtask

  task automatic exp_grant(output bit ga, output bit gl);
    ga = 0; gl = 0;
    if (!reset) begin
      if (alu_wb_valid && lsu_wb_valid) begin
`ifdef RFILE_WB_RR_EN
        if (m_last_lsu) ga = 1; else gl = 1;
`else
        gl = 1;
`endif
      end else begin
        ga = alu_wb_valid;
        gl = lsu_wb_valid;
      end
    end
  endtask

  function automatic bit exp_stall();
    return iss_valid && ((iss_rs1_used && m_pend[iss_rs1]) ||
                         (iss_rs2_used && m_pend[iss_rs2]) ||
                         (iss_writes && m_pend[iss_rd]));
  endfunction

  // One clock cycle: check all outputs against the model, advance the model.
  task automatic tick();
    bit ga, gl, st, fire;
    logic [4:0]  grd, frd;
    logic [31:0] gd;
    #1;
    exp_grant(ga, gl);
    st = exp_stall();
    chk("alu_ready", alu_wb_ready, ga);
    chk("lsu_ready", lsu_wb_ready, gl);
    chk("iss_stall", iss_stall, st);
    chk("rs1_valid", rs1_valid, iss_valid && iss_rs1_used && !st);
    chk("rs2_valid", rs2_valid, iss_valid && iss_rs2_used && !st);
    chk("src_rs1", src_rs1, iss_rs1);
    chk("src_rs2", src_rs2, iss_rs2);
    chk("rd_valid", rd_valid, m_rdv);
    chk("rd", rd, m_rd);
    chk("rd_data", rd_data, m_data);
    chk("wb_err", wb_err, m_err);
    fire = iss_valid && !st && iss_writes && (iss_rd != 0);
    frd  = iss_rd;
    grd  = gl ? lsu_wb_rd : alu_wb_rd;
    gd   = gl ? lsu_wb_data : alu_wb_data;
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if ((ga || gl) && grd != 0 && !m_pend[grd]) m_err = 1;
      if (m_rdv) m_pend[m_rd] = 0;
      if (fire) m_pend[frd] = 1;
      m_rdv = (ga || gl) && grd != 0;
      if (ga || gl) begin m_rd = grd; m_data = gd; end
      if (ga) begin m_last_lsu = 0; void'(alu_q.pop_front()); gnt_log.push_back(0); end
      if (gl) begin m_last_lsu = 1; void'(lsu_q.pop_front()); gnt_log.push_back(1); end
    end
    drive_reqs();
  endtask

  task automatic iss_set(bit v, logic [4:0] r1, bit u1, logic [4:0] r2, bit u2, logic [4:0] d, bit w);
    iss_valid = v; iss_rs1 = r1; iss_rs1_used = u1; iss_rs2 = r2; iss_rs2_used = u2;
    iss_rd = d; iss_writes = w;
  endtask

  task automatic do_reset(int n);
    reset = 1;
    repeat (n) tick();
    reset = 0;
  endtask

  initial begin
    int exp_order[8];
    int rdv_cnt;
    model_reset();
    iss_set(0, 0, 0, 0, 0, 0, 0);
    // Reset with both requesters valid (x0 targets, drained harmlessly later).
    alu_q.push_back('{rd: 5'd0, d: 32'hFFFF_FFFF});
    lsu_q.push_back('{rd: 5'd0, d: 32'h0BAD_0000});
    drive_reqs();
    reset = 1;
    @(posedge clk);
    #1;
    do_reset(2);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wb_err", wb_err, 0);
    repeat (4) tick();
    chk("x0_no_rdv", rd_valid, 0);
    chk("x0_no_err", wb_err, 0);

    // RAW on x5.
    iss_set(1, 0, 0, 0, 0, 5'd5, 1);
    tick();
    iss_set(1, 5'd5, 1, 0, 0, 0, 0);
    tick();
    chk("raw_stall", iss_stall, 1);
    alu_q.push_back('{rd: 5'd5, d: 32'h0000_1234});
    drive_reqs();
    tick();
    chk("raw_rd", rd, 5);
    chk("raw_rd_data", rd_data, 32'h1234);
    chk("raw_rdv", rd_valid, 1);
    tick();
    #1;
    chk("raw_unstall", iss_stall, 0);
    chk("raw_rs1_valid", rs1_valid, 1);
    iss_set(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    // Explicit rd=0 write-back after reset.
    alu_q.push_back('{rd: 5'd0, d: 32'hFFFF_FFFF});
    drive_reqs();
    repeat (3) tick();
    chk("x0b_no_err", wb_err, 0);

    // Write to non-pending x7.
    alu_q.push_back('{rd: 5'd7, d: 32'hA5A5_0007});
    drive_reqs();
    repeat (2) tick();
    chk("err_set", wb_err, 1);
    chk("err_rd", rd, 7);
    repeat (10) tick();
    chk("err_sticky", wb_err, 1);

    // Conflict: x3 (ALU) and x4 (LSU) pending, four requests each.
    do_reset(1);
    iss_set(1, 0, 0, 0, 0, 5'd3, 1); tick();
    iss_set(1, 0, 0, 0, 0, 5'd4, 1); tick();
    iss_set(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      alu_q.push_back('{rd: 5'd3, d: 32'h3000_0000 + i});
      lsu_q.push_back('{rd: 5'd4, d: 32'h4000_0000 + i});
    end
    drive_reqs();
    gnt_log.delete();
    rdv_cnt = 0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (rd_valid === 1'b1) rdv_cnt++;
      tick();
    end
    for (int i = 0; i < 8; i++) begin
`ifdef RFILE_WB_RR_EN
      exp_order[i] = i % 2;
`else
      exp_order[i] = (i < 4) ? 1 : 0;
`endif
    end
    chk("conf_ngrants", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk($sformatf("conf_order%0d", i), gnt_log[i], exp_order[i]);
    chk("conf_rdv_cont", rdv_cnt, 8);

    // WAW plus reset while a write is on the rfile port.
    do_reset(1);
    iss_set(1, 0, 0, 0, 0, 5'd9, 1);
    tick();
    #1;
    chk("waw_stall", iss_stall, 1);
    alu_q.push_back('{rd: 5'd9, d: 32'h0000_0909});
    drive_reqs();
    tick();
    chk("waw_rdv", rd_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("waw_rst_rdv", rd_valid, 0);
    chk("waw_rst_stall", iss_stall, 0);
    chk("waw_rst_err", wb_err, 0);
    iss_set(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic over x0..x7 against the model.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      iss_set($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom_range(0, 1),
              5'($urandom_range(0, 7)), $urandom_range(0, 1),
              5'($urandom_range(0, 7)), $urandom_range(0, 1));
      if (alu_q.size() < 2 && $urandom_range(0, 2) == 0)
        alu_q.push_back('{rd: 5'($urandom_range(0, 7)), d: $urandom});
      if (lsu_q.size() < 2 && $urandom_range(0, 2) == 0)
        lsu_q.push_back('{rd: 5'($urandom_range(0, 7)), d: $urandom});
      if (c == 200) reset = 1;
      if (c == 201) reset = 0;
      drive_reqs();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
